// File: rtl/adder_sweep_controller_if.sv
// Result handshake between the adder sweep sequencer and its consumer (logic analyser or FIFO).
// The master side holds one (bit, count) result until the slave accepts it.
interface adder_sweep_controller_if #(
  parameter int CW = 32
);
  logic          result_valid;
  logic          result_ready;
  logic [2:0]    result_bit;
  logic [CW-1:0] result_count;

  modport master (output result_valid, result_bit, result_count, input result_ready);
  modport slave  (input result_valid, result_bit, result_count, output result_ready);
endinterface

// File: rtl/adder_sweep_controller.sv
// Sweeps a range of adder bit positions and measures the ring oscillator count for each one.
// Define SWEEP_SETTLE_EN to add a ring settle phase between CONFIG and LOAD.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; selects hold the last configured bit
// ST_CONFIG  | drive bit selects, pulse counter_reset
// ST_SETTLE  | ring running with new selection, integration stopped
// ST_LOAD    | load integration time into the adder counter
// ST_RUN     | integrate until done_in (ignored in the first cycle)
// ST_CAPTURE | stop ring, capture ring_count_in
// ST_OUTPUT  | hold result until accepted, then next bit or finish
module adder_sweep_controller #(
  parameter int NBITS         = 8,
  parameter int CW            = 32,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       first_bit,
  input  logic [2:0]       last_bit,
  input  logic [CW-1:0]    integration_time,
  input  logic             done_in,
  input  logic [CW-1:0]    ring_count_in,
  output logic             counter_reset,
  output logic             stop_b,
  output logic [NBITS-1:0] a_input_ring_bit_b,
  output logic [NBITS-1:0] s_output_bit_b,
  output logic             counter_load,
  output logic             counter_enable,
  output logic [CW-1:0]    integration_time_o,
  output logic             busy,
  output logic             sweep_done,
  adder_sweep_controller_if.master res
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CONFIG, ST_SETTLE, ST_LOAD, ST_RUN, ST_CAPTURE, ST_OUTPUT
  } state_t;

  localparam logic [15:0] SETTLE_LOAD = (SETTLE_CYCLES > 0) ? 16'(SETTLE_CYCLES - 1) : 16'd0;
  localparam logic [NBITS-1:0] SEL_NONE = '1;

  state_t            state, state_n;
  logic [2:0]        cur;
  logic [2:0]        last_q;
  logic [NBITS-1:0]  sel_q;
  logic [NBITS-1:0]  sel_cur;
  logic              run_armed;
  logic [15:0]       settle_cnt;
  logic              result_valid;
  logic [2:0]        result_bit;
  logic [CW-1:0]     result_count;
  logic              handshake;
  logic              range_empty;

  assign sel_cur     = ~(NBITS'(1) << cur);
  assign handshake   = result_valid && res.result_ready;
  assign range_empty = first_bit > last_bit;

  assign res.result_valid = result_valid;
  assign res.result_bit   = result_bit;
  assign res.result_count = result_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n            = state;
    counter_reset      = 1'b0;
    counter_load       = 1'b0;
    counter_enable     = 1'b0;
    stop_b             = 1'b0;
    busy               = (state != ST_IDLE);
    a_input_ring_bit_b = (state == ST_IDLE) ? sel_q : sel_cur;
    s_output_bit_b     = (state == ST_IDLE) ? sel_q : sel_cur;

    unique case (state)
      ST_IDLE: begin
        if (start && !range_empty) state_n = ST_CONFIG;
      end
      ST_CONFIG: begin
        counter_reset = 1'b1;
`ifdef SWEEP_SETTLE_EN
        state_n = ST_SETTLE;
`else
        state_n = ST_LOAD;
`endif
      end
      ST_SETTLE: begin
        stop_b = 1'b1;
        if (settle_cnt == 16'd0) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        counter_load = 1'b1;
        stop_b       = 1'b1;
        state_n      = ST_RUN;
      end
      ST_RUN: begin
        counter_enable = 1'b1;
        stop_b         = 1'b1;
        // done_in in the first RUN cycle is left over from the previous run
        if (run_armed && done_in) state_n = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_n = ST_OUTPUT;
      end
      ST_OUTPUT: begin
        if (handshake) state_n = (cur == last_q) ? ST_IDLE : ST_CONFIG;
      end
      default: state_n = ST_IDLE;
    endcase

    if (abort) state_n = ST_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur                <= 3'd0;
      last_q             <= 3'd0;
      integration_time_o <= '0;
      sel_q              <= SEL_NONE;
      run_armed          <= 1'b0;
      settle_cnt         <= 16'd0;
      result_valid       <= 1'b0;
      result_bit         <= 3'd0;
      result_count       <= '0;
      sweep_done         <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      run_armed  <= (state == ST_RUN) && !abort;
      if (abort) begin
        result_valid <= 1'b0;
        sel_q        <= SEL_NONE;
      end else begin
        if (state == ST_IDLE && start) begin
          cur                <= first_bit;
          last_q             <= last_bit;
          integration_time_o <= integration_time;
          if (range_empty) sweep_done <= 1'b1;
        end
        if (state != ST_IDLE) sel_q <= sel_cur;
        if (state == ST_CONFIG) settle_cnt <= SETTLE_LOAD;
        else if (state == ST_SETTLE && settle_cnt != 16'd0) settle_cnt <= settle_cnt - 16'd1;
        if (state == ST_CAPTURE) begin
          result_count <= ring_count_in;
          result_bit   <= cur;
          result_valid <= 1'b1;
        end
        if (state == ST_OUTPUT && handshake) begin
          result_valid <= 1'b0;
          if (cur == last_q) sweep_done <= 1'b1;
          else               cur        <= cur + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_sweep_controller.sv
// Directed bench for adder_sweep_controller with a small model of the adder's integration counter.
// Ring count is modelled as 10 x the selected sum bit index.
module tb_adder_sweep_controller;
  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [2:0]  first_bit, last_bit;
  logic [31:0] integration_time;
  logic        done_in;
  logic [31:0] ring_count_in;
  logic        counter_reset, stop_b, counter_load, counter_enable, busy, sweep_done;
  logic [7:0]  a_input_ring_bit_b, s_output_bit_b;
  logic [31:0] integration_time_o;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  adder_sweep_controller_if #(.CW(32)) res ();

  adder_sweep_controller #(.NBITS(8), .CW(32), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .first_bit(first_bit), .last_bit(last_bit), .integration_time(integration_time),
    .done_in(done_in), .ring_count_in(ring_count_in),
    .counter_reset(counter_reset), .stop_b(stop_b),
    .a_input_ring_bit_b(a_input_ring_bit_b), .s_output_bit_b(s_output_bit_b),
    .counter_load(counter_load), .counter_enable(counter_enable),
    .integration_time_o(integration_time_o), .busy(busy), .sweep_done(sweep_done),
    .res(res)
  );

  // adder integration counter: done flag updates only while enabled, so it is stale after a load
  logic [31:0] int_cnt;
  logic        done_q;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      int_cnt <= 32'd0;
      done_q  <= 1'b0;
    end else if (counter_load) begin
      int_cnt <= integration_time_o;
    end else if (counter_enable) begin
      done_q <= (int_cnt == 32'd0);
      if (int_cnt != 32'd0) int_cnt <= int_cnt - 32'd1;
    end
  end
  assign done_in = done_q;

  always_comb begin
    ring_count_in = 32'd0;
    for (int i = 0; i < 8; i++)
      if (!s_output_bit_b[i]) ring_count_in = 32'(i * 10);
  end

  task automatic pulse_start(input logic [2:0] f, input logic [2:0] l, input logic [31:0] t);
    first_bit = f; last_bit = l; integration_time = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; abort = 1'b0; res.result_ready = 1'b0;
    first_bit = 3'd0; last_bit = 3'd0; integration_time = 32'd0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || stop_b !== 1'b0 || counter_reset !== 1'b0 || counter_load !== 1'b0 ||
        counter_enable !== 1'b0 || sweep_done !== 1'b0 || res.result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy=%b stop_b=%b crst=%b load=%b en=%b done=%b valid=%b, required all 0",
               busy, stop_b, counter_reset, counter_load, counter_enable, sweep_done, res.result_valid);
    end
    tests_run++;
    if (a_input_ring_bit_b !== 8'hFF || s_output_bit_b !== 8'hFF) begin
      tests_failed++;
      $display("FAIL reset_sel: a=%h s=%h, required FF FF", a_input_ring_bit_b, s_output_bit_b);
    end
    tests_run++;
    if (res.result_bit !== 3'd0 || res.result_count !== 32'd0 || integration_time_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_data: bit=%0d count=%0d itime=%0d, required 0 0 0",
               res.result_bit, res.result_count, integration_time_o);
    end
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int seen_run;
    res.result_ready = 1'b1;
    pulse_start(3'd1, 3'd2, 32'd6);
    seen_run = 0;
    // wait for the bit 2 run, after the bit 1 result has been produced
    for (int c = 0; c < 200 && seen_run == 0; c++) begin
      if (counter_enable && a_input_ring_bit_b == 8'hFB) seen_run = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (seen_run != 1) begin
      tests_failed++;
      $display("FAIL midrun_reach: bit 2 run seen=%0d, required 1", seen_run);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || counter_enable !== 1'b0 || stop_b !== 1'b0 || res.result_valid !== 1'b0 ||
        a_input_ring_bit_b !== 8'hFF || s_output_bit_b !== 8'hFF) begin
      tests_failed++;
      $display("FAIL midrun_reset: busy=%b en=%b stop_b=%b valid=%b a=%h s=%h, required 0 0 0 0 FF FF",
               busy, counter_enable, stop_b, res.result_valid, a_input_ring_bit_b, s_output_bit_b);
    end
    tests_run++;
    if (res.result_count !== 32'd0 || res.result_bit !== 3'd0 || integration_time_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL midrun_data: count=%0d bit=%0d itime=%0d, required 0 0 0",
               res.result_count, res.result_bit, integration_time_o);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sweep();
    int nres, ndone, sel_err, run_err, en_len, extra_done;
    logic [7:0] exp_sel;
    res.result_ready = 1'b1;
    pulse_start(3'd2, 3'd4, 32'd100);
    nres = 0; ndone = 0; sel_err = 0; run_err = 0; en_len = 0;
    for (int c = 0; c < 1000 && !(ndone > 0 && !busy); c++) begin
      if (counter_enable) begin
        en_len++;
        exp_sel = ~(8'd1 << (2 + nres));
        if (a_input_ring_bit_b !== exp_sel || s_output_bit_b !== exp_sel) sel_err++;
      end else if (en_len != 0) begin
        // load 100, done flag registered: 102 enable cycles per bit
        if (en_len != 102) run_err++;
        en_len = 0;
      end
      if (res.result_valid) begin
        tests_run++;
        if (res.result_bit !== 3'(2 + nres) || res.result_count !== 32'((2 + nres) * 10)) begin
          tests_failed++;
          $display("FAIL sweep_result%0d: bit=%0d count=%0d, required %0d %0d",
                   nres, res.result_bit, res.result_count, 2 + nres, (2 + nres) * 10);
        end
        nres++;
      end
      if (sweep_done) begin
        ndone++;
        tests_run++;
        if (nres != 3) begin
          tests_failed++;
          $display("FAIL sweep_done_order: results before done=%0d, required 3", nres);
        end
      end
      @(negedge clk);
    end
    extra_done = 0;
    for (int c = 0; c < 5; c++) begin
      if (sweep_done) extra_done++;
      @(negedge clk);
    end
    tests_run++;
    if (nres != 3 || ndone != 1 || extra_done != 0) begin
      tests_failed++;
      $display("FAIL sweep_counts: results=%0d done_pulses=%0d, required 3 1", nres, ndone + extra_done);
    end
    tests_run++;
    if (sel_err != 0) begin
      tests_failed++;
      $display("FAIL sweep_selects: bad select cycles=%0d, required 0", sel_err);
    end
    tests_run++;
    if (run_err != 0) begin
      tests_failed++;
      $display("FAIL sweep_run_len: runs of wrong length=%0d, required 0", run_err);
    end
  endtask

  task automatic test_backpressure();
    int got, hold_err;
    res.result_ready = 1'b0;
    pulse_start(3'd5, 3'd5, 32'd3);
    got = 0;
    for (int c = 0; c < 200 && got == 0; c++) begin
      if (res.result_valid) got = 1;
      else @(negedge clk);
    end
    tests_run++;
    if (got != 1) begin
      tests_failed++;
      $display("FAIL bp_valid: result_valid seen=%0d, required 1", got);
    end
    hold_err = 0;
    for (int c = 0; c < 20; c++) begin
      if (!res.result_valid || res.result_bit !== 3'd5 || res.result_count !== 32'd50 || sweep_done)
        hold_err++;
      @(negedge clk);
    end
    tests_run++;
    if (hold_err != 0) begin
      tests_failed++;
      $display("FAIL bp_hold: unstable cycles=%0d, required 0", hold_err);
    end
    res.result_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if (sweep_done !== 1'b1 || res.result_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_release: done=%b valid=%b, required 1 0", sweep_done, res.result_valid);
    end
    @(negedge clk);
    tests_run++;
    if (sweep_done !== 1'b0 || busy !== 1'b0 || a_input_ring_bit_b !== 8'hDF || s_output_bit_b !== 8'hDF) begin
      tests_failed++;
      $display("FAIL bp_idle: done=%b busy=%b a=%h s=%h, required 0 0 DF DF",
               sweep_done, busy, a_input_ring_bit_b, s_output_bit_b);
    end
  endtask

  task automatic test_empty_range();
    int bad;
    pulse_start(3'd6, 3'd1, 32'd10);
    tests_run++;
    if (sweep_done !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL empty_done: done=%b busy=%b, required 1 0", sweep_done, busy);
    end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (busy || counter_load || counter_enable || sweep_done) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL empty_quiet: active cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_abort();
    int seen, bad, got, done_seen;
    res.result_ready = 1'b1;
    abort = 1'b1; first_bit = 3'd0; last_bit = 3'd3; integration_time = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || counter_reset !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_start: busy=%b crst=%b, required 0 0", busy, counter_reset);
    end
    pulse_start(3'd0, 3'd7, 32'd20);
    seen = 0;
    for (int c = 0; c < 500 && seen == 0; c++) begin
      if (counter_enable && a_input_ring_bit_b == 8'hF7) seen = 1;
      else @(negedge clk);
    end
    @(negedge clk); @(negedge clk); @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests_run++;
    if (seen != 1 || busy !== 1'b0 || counter_enable !== 1'b0 || stop_b !== 1'b0 ||
        res.result_valid !== 1'b0 || a_input_ring_bit_b !== 8'hFF || s_output_bit_b !== 8'hFF) begin
      tests_failed++;
      $display("FAIL abort_idle: seen=%0d busy=%b en=%b stop_b=%b valid=%b a=%h s=%h, required 1 0 0 0 0 FF FF",
               seen, busy, counter_enable, stop_b, res.result_valid, a_input_ring_bit_b, s_output_bit_b);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      if (sweep_done || res.result_valid || busy) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: active cycles=%0d, required 0", bad);
    end
    pulse_start(3'd1, 3'd1, 32'd5);
    got = 0; done_seen = 0;
    for (int c = 0; c < 200 && done_seen == 0; c++) begin
      if (res.result_valid) begin
        got++;
        tests_run++;
        if (res.result_bit !== 3'd1 || res.result_count !== 32'd10) begin
          tests_failed++;
          $display("FAIL abort_restart_result: bit=%0d count=%0d, required 1 10",
                   res.result_bit, res.result_count);
        end
      end
      if (sweep_done) done_seen = 1;
      @(negedge clk);
    end
    tests_run++;
    if (got != 1 || done_seen != 1) begin
      tests_failed++;
      $display("FAIL abort_restart: results=%0d done=%0d, required 1 1", got, done_seen);
    end
  endtask

  task automatic test_config_to_load();
    int gap, armed, loaded, exp_gap, done_seen;
`ifdef SWEEP_SETTLE_EN
    exp_gap = 4;
`else
    exp_gap = 0;
`endif
    res.result_ready = 1'b1;
    pulse_start(3'd0, 3'd0, 32'd2);
    gap = 0; armed = 0; loaded = 0;
    for (int c = 0; c < 50 && loaded == 0; c++) begin
      if (counter_reset) armed = 1;
      else if (counter_load) loaded = 1;
      else if (armed != 0 && stop_b && !counter_enable) gap++;
      @(negedge clk);
    end
    tests_run++;
    if (loaded != 1 || gap != exp_gap) begin
      tests_failed++;
      $display("FAIL settle_gap: loaded=%0d gap=%0d, required 1 %0d", loaded, gap, exp_gap);
    end
    done_seen = 0;
    for (int c = 0; c < 100 && done_seen == 0; c++) begin
      if (sweep_done) done_seen = 1;
      @(negedge clk);
    end
    tests_run++;
    if (done_seen != 1) begin
      tests_failed++;
      $display("FAIL settle_done: done seen=%0d, required 1", done_seen);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_sweep();
    test_backpressure();
    test_empty_range();
    test_abort();
    test_config_to_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
